// File: rtl/shift_pkg.sv
// Purpose: shared op/state encodings and bit-reversal helper for the shift arbiter slice.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package shift_pkg;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  // Mirror a word end-for-end so a left shifter can perform right shifts.
  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = d[WIDTH-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_core.sv
// Purpose: combinational 32-bit shifter (SLL/SRL/SRA/ROL) built around one left-shift core.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
// Build option: ROTATE_EN enables real rotate for op 11; otherwise op 11 passes data through.
module shift_core
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] i_data,
  input  logic [AMT_W-1:0] i_amt,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_result
);

  logic             w_is_right;
  logic [WIDTH-1:0] w_core_in;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_srl;
  logic [WIDTH-1:0] w_fill;

  // Right shifts go through the same left shifter by mirroring input and output.
  assign w_is_right = (i_op == OP_SRL) || (i_op == OP_SRA);
  assign w_core_in  = w_is_right ? bit_rev(i_data) : i_data;
  assign w_shl      = w_core_in << i_amt;
  assign w_srl      = bit_rev(w_shl);
  // Sign fill covers exactly the vacated MSBs; empty when amt is 0.
  assign w_fill     = i_data[WIDTH-1] ? ~({WIDTH{1'b1}} >> i_amt) : '0;

`ifdef ROTATE_EN
  logic [WIDTH-1:0] w_rol_hi;
  // Shift by 32 when amt is 0 clears the wrap term, leaving data unchanged.
  assign w_rol_hi = i_data >> (6'd32 - {1'b0, i_amt});
`endif

  // Select the final result per op.
  always_comb begin
    o_result = w_shl;
    case (op_e'(i_op))
      OP_SLL: o_result = w_shl;
      OP_SRL: o_result = w_srl;
      OP_SRA: o_result = w_srl | w_fill;
`ifdef ROTATE_EN
      OP_ROL: o_result = w_shl | w_rol_hi;
`else
      OP_ROL: o_result = i_data;
`endif
      default: o_result = w_shl;
    endcase
  end

endmodule

// File: rtl/shift_arbiter_ctrl.sv
// Purpose: round-robin share of one shift datapath between ALU (port 0) and multdiv (port 1).
// Latency: 1 cycle from accept to rsp_valid; back-to-back issue when rsp_ready is high.
// Backpressure: rsp_ready=0 holds the result and drops both reqN_ready. Build option: ROTATE_EN.
module shift_arbiter_ctrl
  import shift_pkg::state_e;
  import shift_pkg::ST_IDLE;
  import shift_pkg::ST_FULL;
  import shift_pkg::OP_ROL;
  import shift_pkg::AMT_W;
#(
  parameter int WIDTH      = 32,
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_rr_ptr;
  logic             r_id;
  logic [WIDTH-1:0] r_data;
  logic             r_err;

  logic             w_can_accept;
  logic             w_both;
  logic             w_winner;
  logic             w_grant;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_data;
  logic [AMT_W-1:0] w_amt;
  logic [WIDTH-1:0] w_result;
  logic             w_err;

  // The output slot frees up in the same cycle the consumer drains it.
  assign w_can_accept = (r_state == ST_IDLE) | rsp_ready;
  assign w_both       = req0_valid & req1_valid;
  assign w_winner     = w_both ? r_rr_ptr : req1_valid;
  assign w_grant      = w_can_accept & (req0_valid | req1_valid);

  assign req0_ready   = w_can_accept & req0_valid & ~w_winner;
  assign req1_ready   = w_can_accept & req1_valid &  w_winner;

  assign w_op   = w_winner ? req1_op   : req0_op;
  assign w_data = w_winner ? req1_data : req0_data;
  assign w_amt  = w_winner ? req1_amt  : req0_amt;

`ifdef ROTATE_EN
  assign w_err = 1'b0;
`else
  assign w_err = (w_op == OP_ROL);
`endif

  shift_core u_core (
    .i_data   (w_data),
    .i_amt    (w_amt),
    .i_op     (w_op),
    .o_result (w_result)
  );

  // State register: IDLE means the output slot is empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: fill on grant, empty when drained with nothing new, else hold.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_state_nxt = ST_FULL;
      ST_FULL: if (rsp_ready && !w_grant) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Round-robin pointer only moves when both ports competed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 r_rr_ptr <= RESET_PRIO;
    else if (w_grant && w_both) r_rr_ptr <= ~w_winner;
  end

  // Result register: captured on grant, otherwise held so rsp_* stays stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_id   <= 1'b0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else if (w_grant) begin
      r_id   <= w_winner;
      r_data <= w_result;
      r_err  <= w_err;
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Purpose: self-checking bench for shift_arbiter_ctrl against a queue-free slot model.
// Latency: model expects results one edge after accept.
// Backpressure: model holds its single response slot while rsp_ready is low.
module tb_shift_arbiter_ctrl;

  logic        clock;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  req0_amt, req1_amt;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_err    = 0;

  // Model: one response slot plus the priority holder.
  bit          m_valid;
  bit          m_id;
  bit          m_err;
  logic [31:0] m_data;
  bit          m_prio;

  shift_arbiter_ctrl #(.WIDTH(32), .RESET_PRIO(1'b0)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {err, data} straight from the op definitions.
  function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] d,
                                        input logic [4:0] a);
    logic [31:0] r;
    case (op)
      2'b00: r = d << a;
      2'b01: r = d >> a;
      2'b10: r = $signed(d) >>> a;
      default: begin
`ifdef ROTATE_EN
        if (a == 0) r = d;
        else        r = (d << a) | (d >> (32 - int'(a)));
        return {1'b0, r};
`else
        return {1'b1, d};
`endif
      end
    endcase
    return {1'b0, r};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_err = 0; m_data = '0; m_prio = 1'b0;
  endtask

  // One clock cycle: compare DUT against model, advance model, cross the edge.
  task automatic step();
    bit can, any, win;
    logic [32:0] r;
    #1;
    can = !m_valid || rsp_ready;
    any = req0_valid || req1_valid;
    win = (req0_valid && req1_valid) ? m_prio : req1_valid;
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, can && req0_valid && !win});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, can && req1_valid && win});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("rsp_id",   {31'b0, rsp_id},  {31'b0, m_id});
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_err",  {31'b0, rsp_err}, {31'b0, m_err});
    end
    if (can && any) begin
      r = win ? model(req1_op, req1_data, req1_amt) : model(req0_op, req0_data, req0_amt);
      m_valid = 1; m_id = win; m_data = r[31:0]; m_err = r[32];
      if (req0_valid && req1_valid) m_prio = !win;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_in(input bit v0, input logic [1:0] o0, input logic [31:0] d0,
                        input logic [4:0] a0, input bit v1, input logic [1:0] o1,
                        input logic [31:0] d1, input logic [4:0] a1, input bit rr);
    req0_valid = v0; req0_op = o0; req0_data = d0; req0_amt = a0;
    req1_valid = v1; req1_op = o1; req1_data = d1; req1_amt = a1;
    rsp_ready  = rr;
  endtask

  task automatic drive(input bit v0, input logic [1:0] o0, input logic [31:0] d0,
                       input logic [4:0] a0, input bit v1, input logic [1:0] o1,
                       input logic [31:0] d1, input logic [4:0] a1, input bit rr);
    set_in(v0, o0, d0, a0, v1, o1, d1, a1, rr);
    step();
  endtask

  initial begin
    bit exp_id [4];
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
    reset = 1'b1;
    set_in(0, 2'b00, 32'h0, 5'd0, 0, 2'b00, 32'h0, 5'd0, 1);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    chk("reset_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset_id",    {31'b0, rsp_id},    32'h0);
    chk("reset_data",  rsp_data,           32'h0);
    chk("reset_err",   {31'b0, rsp_err},   32'h0);
    reset = 1'b0;

    // Contention straight out of reset: port 0 first, then alternate.
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'b00, 32'hA0 + i, 5'd0, 1, 2'b00, 32'hB0 + i, 5'd0, 1);
      chk("contend_id", {31'b0, rsp_id}, {31'b0, exp_id[i]});
      chk("contend_data", rsp_data, exp_id[i] ? 32'hB0 + i : 32'hA0 + i);
    end
    drive(0, 2'b00, 32'h0, 5'd0, 0, 2'b00, 32'h0, 5'd0, 1);

    // Single-op literals.
    drive(1, 2'b00, 32'h0000_0001, 5'd31, 0, 2'b00, 32'h0, 5'd0, 1);
    chk("sll31", rsp_data, 32'h8000_0000);
    chk("sll31_id", {31'b0, rsp_id}, 32'h0);
    drive(1, 2'b01, 32'h8000_0000, 5'd4, 0, 2'b00, 32'h0, 5'd0, 1);
    chk("srl4", rsp_data, 32'h0800_0000);
    drive(1, 2'b10, 32'h8000_00F0, 5'd4, 0, 2'b00, 32'h0, 5'd0, 1);
    chk("sra_neg", rsp_data, 32'hF800_000F);
    drive(0, 2'b00, 32'h0, 5'd0, 1, 2'b10, 32'h7000_0000, 5'd4, 1);
    chk("sra_pos", rsp_data, 32'h0700_0000);
    chk("sra_pos_id", {31'b0, rsp_id}, 32'h1);
    drive(1, 2'b10, 32'h8000_00F0, 5'd0, 0, 2'b00, 32'h0, 5'd0, 1);
    chk("sra_amt0", rsp_data, 32'h8000_00F0);
    drive(1, 2'b11, 32'h8000_0001, 5'd1, 0, 2'b00, 32'h0, 5'd0, 1);
`ifdef ROTATE_EN
    chk("rol1", rsp_data, 32'h0000_0003);
    chk("rol1_err", {31'b0, rsp_err}, 32'h0);
`else
    chk("op11_data", rsp_data, 32'h8000_0001);
    chk("op11_err", {31'b0, rsp_err}, 32'h1);
`endif

    // Backpressure: hold 0x12345678 for three cycles with both ports waiting.
    drive(0, 2'b00, 32'h0, 5'd0, 1, 2'b00, 32'h1234_5678, 5'd0, 1);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 2'b01, 32'hFFFF_0000, 5'd8, 1, 2'b00, 32'h0000_FFFF, 5'd8, 0);
      #1;
      chk("bp_ready", {30'b0, req0_ready, req1_ready}, 32'h0);
      step();
      chk("bp_data", rsp_data, 32'h1234_5678);
      chk("bp_valid", {31'b0, rsp_valid}, 32'h1);
    end
    set_in(1, 2'b01, 32'hFFFF_0000, 5'd8, 1, 2'b00, 32'h0000_FFFF, 5'd8, 1);
    #1;
    chk("bp_release", {31'b0, req0_ready | req1_ready}, 32'h1);
    step();

    // Reset while a result is held.
    chk("pre_reset_valid", {31'b0, rsp_valid}, 32'h1);
    reset = 1'b1;
    #1;
    chk("midreset_valid", {31'b0, rsp_valid}, 32'h0);
    chk("midreset_data", rsp_data, 32'h0);
    model_reset();
    set_in(0, 2'b00, 32'h0, 5'd0, 0, 2'b00, 32'h0, 5'd0, 1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    drive(1, 2'b00, 32'h1, 5'd1, 1, 2'b00, 32'h2, 5'd1, 1);
    chk("post_reset_prio", {31'b0, rsp_id}, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] d0, d1;
      d0 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      d1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), d0, 5'($urandom_range(0, 31)),
            $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), d1, 5'($urandom_range(0, 31)),
            $urandom_range(0, 3) != 0);
    end
    drive(0, 2'b00, 32'h0, 5'd0, 0, 2'b00, 32'h0, 5'd0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
